ysyx_axi4_sram: RTL

//  AXI4 slave memory that sits directly downstream of the core's io_master port.

---
 rtl/ysyx_axi4_sram.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_axi4_sram.sv
// ysyx_axi4_sram -- AXI4 slave word memory used as main memory for the core's
// io_master port in standalone simulation.
//
// One transaction at a time. Supports FIXED and INCR bursts, and the read
// latency is programmable.
//
// Ports
//   clock, reset                  clock (rising edge) and asynchronous active-low reset
//   ar* / arvalid / arready       read address channel
//   rid, rlast, rdata, rresp,
//   rvalid / rready               read data channel
//   aw* / awvalid / awready       write address channel
//   wdata, wstrb, wlast,
//   wvalid / wready               write data channel
//   bid, bresp, bvalid / bready   write response channel
//
// Response codes
//   OKAY   00
//   SLVERR 10  size > 2, WRAP burst, or wlast misplaced
//   DECERR 11  beat address outside the mapped window
module ysyx_axi4_sram #(
   parameter int              XLEN       = 32,
   parameter int              MEM_WORDS  = 65536,
   parameter logic [XLEN-1:0] BASE_ADDR  = 32'h8000_0000,
   parameter int              RD_LATENCY = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [1:0]        arburst,
   input  logic [2:0]        arsize,
   input  logic [7:0]        arlen,
   input  logic [3:0]        arid,
   input  logic [XLEN-1:0]   araddr,
   input  logic              arvalid,
   output logic              arready,
   output logic [3:0]        rid,
   output logic              rlast,
   output logic [XLEN-1:0]   rdata,
   output logic [1:0]        rresp,
   output logic              rvalid,
   input  logic              rready,
   input  logic [1:0]        awburst,
   input  logic [2:0]        awsize,
   input  logic [7:0]        awlen,
   input  logic [3:0]        awid,
   input  logic [XLEN-1:0]   awaddr,
   input  logic              awvalid,
   output logic              awready,
   input  logic [XLEN-1:0]   wdata,
   input  logic [XLEN/8-1:0] wstrb,
   input  logic              wlast,
   input  logic              wvalid,
   output logic              wready,
   output logic [3:0]        bid,
   output logic [1:0]        bresp,
   output logic              bvalid,
   input  logic              bready
);

   localparam int            AW        = $clog2(MEM_WORDS);
   localparam int            NB        = XLEN / 8;
   localparam logic [XLEN:0] MEM_BYTES = (XLEN+1)'(4 * MEM_WORDS);
   localparam logic [7:0]    LAT_INIT  = 8'(RD_LATENCY - 1);

   typedef enum logic [2:0] {S_IDLE, S_RD_LAT, S_RD_BEAT, S_WR_DATA, S_WR_RESP} state_t;

   state_t          state_q, state_d;
   logic [3:0]      id_q, id_d;
   logic [XLEN-1:0] addr_q, addr_d;     // address of the current beat
   logic [7:0]      len_q, len_d;
   logic [2:0]      size_q, size_d;
   logic [1:0]      burst_q, burst_d;
   logic [7:0]      beat_q, beat_d;
   logic [7:0]      cnt_q, cnt_d;
   logic            slv_q, slv_d;       // sticky write-burst SLVERR
   logic            dec_q, dec_d;       // sticky write-burst DECERR

   logic [XLEN-1:0] offset;
   logic            beat_in_range;
   logic            burst_bad;
   logic [XLEN-1:0] next_addr;
   logic            wr_en;
   logic [AW-1:0]   wr_idx;
   logic            rd_en;
   logic [AW-1:0]   rd_idx;
   logic [XLEN-1:0] rdata_q;

   // Unsigned offset: addresses below BASE_ADDR wrap to huge values and fail the range test.
   assign offset        = addr_q - BASE_ADDR;
   assign beat_in_range = {1'b0, offset} < MEM_BYTES;
   assign burst_bad     = (size_q > 3'd2) || (burst_q == 2'b10);
   assign next_addr     = (burst_q == 2'b00) ? addr_q : addr_q + (XLEN'(1) << size_q);

   assign wr_en  = (state_q == S_WR_DATA) && wvalid && beat_in_range && !burst_bad;
   assign wr_idx = AW'(offset >> 2);

   // The RAM read is launched on the edge that presents a new beat, so the
   // registered word is ready the cycle rvalid rises or the beat advances.
   assign rd_en  = (state_d == S_RD_BEAT) && ((state_q != S_RD_BEAT) || (rvalid && rready));
   assign rd_idx = AW'((addr_d - BASE_ADDR) >> 2);

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      addr_d  = addr_q;
      len_d   = len_q;
      size_d  = size_q;
      burst_d = burst_q;
      beat_d  = beat_q;
      cnt_d   = cnt_q;
      slv_d   = slv_q;
      dec_d   = dec_q;
      arready = 1'b0;
      awready = 1'b0;
      rvalid  = 1'b0;
      wready  = 1'b0;
      bvalid  = 1'b0;
      case (state_q)
         S_IDLE: begin
            arready = 1'b1;
            awready = !arvalid;          // a simultaneous read takes priority
            if (arvalid) begin
               id_d    = arid;
               addr_d  = araddr;
               len_d   = arlen;
               size_d  = arsize;
               burst_d = arburst;
               beat_d  = 8'd0;
               cnt_d   = LAT_INIT;
               state_d = (RD_LATENCY <= 1) ? S_RD_BEAT : S_RD_LAT;
            end else if (awvalid) begin
               id_d    = awid;
               addr_d  = awaddr;
               len_d   = awlen;
               size_d  = awsize;
               burst_d = awburst;
               beat_d  = 8'd0;
               slv_d   = 1'b0;
               dec_d   = 1'b0;
               state_d = S_WR_DATA;
            end
         end
         S_RD_LAT: begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q <= 8'd1) state_d = S_RD_BEAT;
         end
         S_RD_BEAT: begin
            rvalid = 1'b1;
            if (rready) begin
               if (beat_q == len_q) begin
                  state_d = S_IDLE;
               end else begin
                  beat_d = beat_q + 8'd1;
                  addr_d = next_addr;
               end
            end
         end
         S_WR_DATA: begin
            wready = 1'b1;
            if (wvalid) begin
               if (!beat_in_range) dec_d = 1'b1;
               if (burst_bad || (wlast != (beat_q == len_q))) slv_d = 1'b1;
               // The burst length comes from awlen alone; wlast only affects bresp.
               if (beat_q == len_q) begin
                  state_d = S_WR_RESP;
               end else begin
                  beat_d = beat_q + 8'd1;
                  addr_d = next_addr;
               end
            end
         end
         S_WR_RESP: begin
            bvalid = 1'b1;
            if (bready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         id_q    <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         size_q  <= '0;
         burst_q <= '0;
         beat_q  <= '0;
         cnt_q   <= '0;
         slv_q   <= 1'b0;
         dec_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         size_q  <= size_d;
         burst_q <= burst_d;
         beat_q  <= beat_d;
         cnt_q   <= cnt_d;
         slv_q   <= slv_d;
         dec_q   <= dec_d;
      end
   end

   // One byte-wide RAM per lane. Contents survive reset.
   for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] mem_q [MEM_WORDS];
      logic [7:0] rd_byte_q;
      always_ff @(posedge clock) begin
         if (wr_en && wstrb[gi]) mem_q[wr_idx] <= wdata[gi*8 +: 8];
         if (rd_en) rd_byte_q <= mem_q[rd_idx];
      end
      assign rdata_q[gi*8 +: 8] = rd_byte_q;
   end

   assign rdata = (rvalid && beat_in_range && !burst_bad) ? rdata_q : '0;
   assign rresp = !rvalid        ? 2'b00 :
                  !beat_in_range ? 2'b11 :
                  burst_bad      ? 2'b10 : 2'b00;
   assign rlast = rvalid && (beat_q == len_q);
   assign rid   = id_q;
   assign bid   = id_q;
   assign bresp = !bvalid ? 2'b00 :
                  dec_q   ? 2'b11 :
                  slv_q   ? 2'b10 : 2'b00;

endmodule
